alu_mul_seq: RTL and testbench
==============================

# alu_mul_seq

Multi-cycle sequencer that computes an unsigned 8×8→16 product by driving the 8-bit ALU's control inputs in shift-and-add order. It sits between the control unit and the ALU. While it runs, it owns the ALU control lines, the ALU `A` operand and the shared bus. Results leave on a 16-bit output with a one-cycle done pulse.

## Interface
Parameters: none; widths are fixed at 8-bit data and 16-bit product.

- `i_clk` in 1: system clock, rising edge.
- `i_nReset` in 1: synchronous, active-low reset.
- `i_start` in 1: start request; sampled only in IDLE.
- `i_multiplicand` in 8: operand A; latched on the accepted start.
- `i_multiplier` in 8: operand B; latched on the accepted start.
- `o_busy` in/out: out 1; high from the cycle after the accepted start through the DONE cycle.
- `o_done` out 1: one-cycle pulse; `o_product` is valid.
- `o_product` out 16: `{acc_hi, acc_lo}`; holds until the next accepted start.
- `o_aluA` out 8: ALU `A` operand (= `acc_hi`).
- `o_bus` out 8: value driven onto the shared bus (multiplicand, or 0x00).
- `o_busNOE` out 1: active-low enable for the sequencer's bus driver.
- `i_bus` in 8: shared bus readback (the registered ALU result).
- `i_flagCarry` in 1: ALU carry flag.
- `o_ctrlAluYNWE` out 1: ALU result/flag write enable, active-low.
- `o_ctrlAluNOE` out 1: ALU bus output enable, active-low.
- `o_ctrlAluSub` out 1: ALU subtract/reverse select; always 0.
- `o_ctrlAluOp` out 2: ALU op select; always ADD (2'b00).

## Operation
- Internal state:
  - `acc_hi[7:0]`, `acc_lo[7:0]` (multiplier shifts out, product low bits shift in).
  - `mcand[7:0]`.
  - `iter[2:0]`.
- States:
  - IDLE: all enables inactive.
  - ADD: `o_bus=mcand`, `o_busNOE=0`, `o_ctrlAluYNWE=0`.
  - READ: `o_busNOE=1`, `o_ctrlAluNOE=0`. The registers update with `{acc_hi,acc_lo} <= {i_flagCarry, i_bus, acc_lo} >> 1`.
  - SHIFT: no ALU access. The registers update with `{acc_hi,acc_lo} <= {1'b0, acc_hi, acc_lo} >> 1`.
  - DONE: `o_done=1`.
- IDLE + `i_start`:
  - `mcand <= A`, `acc_lo <= B`, `acc_hi <= 0`, `iter <= 0`.
  - Next state is ADD if `B[0]`, else SHIFT.
- ADD → READ, unconditionally.
- READ or SHIFT:
  - If `iter==7`, go to DONE.
  - Otherwise `iter++`. The next state is ADD if the post-shift `acc_lo[0]` is set, else SHIFT.
- DONE → IDLE, unconditionally.
- `i_start` outside IDLE is ignored, including in DONE.
- Bus exclusivity:
  - `o_busNOE` and `o_ctrlAluNOE` are never both low in the same cycle.
  - Outside ADD/READ, both are high.
- Arithmetic is unsigned.
  - The 9th bit of every partial sum comes from `i_flagCarry`, which the ALU registers at the same edge as its result.
  - The maximum product is 0xFE01. Overflow is impossible.

## Timing
- Reset (`i_nReset=0` at an edge):
  - State → IDLE. `acc_hi`, `acc_lo`, `mcand` and `iter` → 0.
  - `o_busy=0`, `o_done=0`, `o_product=0x0000`.
  - `o_busNOE=1`, `o_ctrlAluYNWE=1`, `o_ctrlAluNOE=1`, `o_ctrlAluSub=0`, `o_ctrlAluOp=00`, `o_bus=0`, `o_aluA=0`.
- Reset mid-operation aborts immediately. No partial result is kept.
- All outputs are registered-state decodes (Moore). No combinational path from inputs to outputs.
- ALU latency:
  - In ADD, the result is written at the ADD→READ edge.
  - In READ, the ALU drives the bus. Its result is captured at the READ exit edge.
- Total latency: DONE is entered 8 + popcount(B) edges after the edge that sampled `i_start`. The next start can be accepted 2 cycles after DONE is entered.
- B=0x00 is the minimum case (8 cycles). B=0xFF is the maximum case (16 cycles).

## Configuration
- `ALU_MUL_SEQ_ZERO_SKIP_EN` defined: zero bits take a SHIFT state (1 cycle), giving the latency 8 + popcount(B) above.
- Undefined: constant-time operation.
  - Every iteration goes through ADD→READ. For a zero multiplier bit, `o_bus=0x00`.
  - SHIFT is never entered. Latency is fixed at 16 cycles for any B.

## Structure
- Package `alu_mul_seq_pkg`:
  - state enum `{IDLE, ADD, READ, SHIFT, DONE}`.
  - ALU op constants: `ALU_OP_ADD=2'b00`, `ALU_OP_AND=2'b01`, `ALU_OP_XOR=2'b10`, `ALU_OP_SHIFT=2'b11`.
  - `MUL_ITERATIONS=8`.
- Single module, no sub-module.
- The bench instantiates the real ALU and a bus-resolution model that flags contention.

## Test plan
- 0x0F × 0x11 → `o_product=0x00FF`, `o_done` pulse. With skip, DONE is 10 edges after start; without skip, 16.
- 0xFF × 0xFF → 0xFE01. Exercises the carry into `acc_hi` on every iteration. Latency 16 in both builds.
- 0x80 × 0x00 → 0x0000. The ALU is never written with skip (`o_ctrlAluYNWE` stays high). Latency 8 with skip.
- `i_start` pulsed during ADD/READ/DONE with new operands → ignored. The first product stays correct and no second `o_done` occurs.
- `i_nReset=0` at iteration 4 of 0xAA × 0x55, then start 0x03 × 0x07 → all reset values hold, then 0x0015.
- Random 1000 operand pairs → matches A*B. The bus monitor never sees `o_busNOE` and `o_ctrlAluNOE` both low.

Source files
------------

// File: rtl/alu_mul_seq_pkg.sv
// Shared types and constants for the shift-and-add multiply sequencer.
// Build option: ALU_MUL_SEQ_ZERO_SKIP_EN selects zero-bit skipping
// (variable latency). When it is undefined, every iteration runs through the ALU.
package alu_mul_seq_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ADD   = 3'd1,
        READ  = 3'd2,
        SHIFT = 3'd3,
        DONE  = 3'd4
    } state_e;

    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_AND   = 2'b01;
    localparam logic [1:0] ALU_OP_XOR   = 2'b10;
    localparam logic [1:0] ALU_OP_SHIFT = 2'b11;

    localparam int         MUL_ITERATIONS = 8;
    localparam logic [2:0] LAST_ITER      = 3'(MUL_ITERATIONS - 1);

`ifdef ALU_MUL_SEQ_ZERO_SKIP_EN
    localparam bit ZERO_SKIP_EN = 1'b1;
`else
    localparam bit ZERO_SKIP_EN = 1'b0;
`endif

    // First state of an iteration. A zero multiplier bit bypasses the ALU
    // only when skipping is enabled.
    function automatic state_e iter_entry_state(input logic mbit_i);
        if (mbit_i || !ZERO_SKIP_EN) begin
            iter_entry_state = ADD;
        end else begin
            iter_entry_state = SHIFT;
        end
    endfunction

    // Value placed on the bus for the ALU add. A zero bit adds 0x00, so the
    // constant-time build still runs the ALU path without changing the sum.
    function automatic logic [7:0] add_operand(input logic [7:0] mcand_i,
                                               input logic       mbit_i);
        if (mbit_i) begin
            add_operand = mcand_i;
        end else begin
            add_operand = 8'h00;
        end
    endfunction

endpackage

// File: rtl/alu_mul_seq.sv
// Unsigned 8x8->16 shift-and-add multiplier that drives the shared 8-bit ALU.
// The ALU A operand is acc_hi. The multiplicand is placed on the shared bus
// in ADD. The registered ALU sum and carry are read back in READ.
// Build option: ALU_MUL_SEQ_ZERO_SKIP_EN. When it is defined, zero multiplier
// bits take a one-cycle SHIFT state. When it is undefined, the latency is a
// constant 16 cycles.
// All outputs come from registers. No input reaches an output combinationally.
module alu_mul_seq
    import alu_mul_seq_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_nReset,
    input  logic        i_start,
    input  logic [7:0]  i_multiplicand,
    input  logic [7:0]  i_multiplier,
    output logic        o_busy,
    output logic        o_done,
    output logic [15:0] o_product,
    output logic [7:0]  o_aluA,
    output logic [7:0]  o_bus,
    output logic        o_busNOE,
    input  logic [7:0]  i_bus,
    input  logic        i_flagCarry,
    output logic        o_ctrlAluYNWE,
    output logic        o_ctrlAluNOE,
    output logic        o_ctrlAluSub,
    output logic [1:0]  o_ctrlAluOp
);

    state_e     state_q, state_d;
    logic [7:0] acc_hi_q, acc_hi_d;
    logic [7:0] acc_lo_q, acc_lo_d;
    logic [7:0] mcand_q, mcand_d;
    logic [2:0] iter_q, iter_d;
    logic       advance_s;

    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic [7:0] bus_q, bus_d;
    logic       bus_noe_q, bus_noe_d;
    logic       alu_ynwe_q, alu_ynwe_d;
    logic       alu_noe_q, alu_noe_d;

    // Next-state and datapath update for the multiply sequence.
    always_comb begin
        state_d   = state_q;
        acc_hi_d  = acc_hi_q;
        acc_lo_d  = acc_lo_q;
        mcand_d   = mcand_q;
        iter_d    = iter_q;
        advance_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_start) begin
                    mcand_d  = i_multiplicand;
                    acc_lo_d = i_multiplier;
                    acc_hi_d = 8'h00;
                    iter_d   = 3'd0;
                    state_d  = iter_entry_state(i_multiplier[0]);
                end else begin
                    state_d = IDLE;
                end
            end
            ADD: begin
                state_d = READ;
            end
            READ: begin
                // The 9-bit partial sum {carry, result} shifts right into the accumulator.
                acc_hi_d  = {i_flagCarry, i_bus[7:1]};
                acc_lo_d  = {i_bus[0], acc_lo_q[7:1]};
                advance_s = 1'b1;
            end
            SHIFT: begin
                acc_hi_d  = {1'b0, acc_hi_q[7:1]};
                acc_lo_d  = {acc_hi_q[0], acc_lo_q[7:1]};
                advance_s = 1'b1;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (advance_s) begin
            if (iter_q == LAST_ITER) begin
                state_d = DONE;
            end else begin
                iter_d  = iter_q + 3'd1;
                // acc_lo_q[1] is the post-shift LSB, which is the next multiplier bit.
                state_d = iter_entry_state(acc_lo_q[1]);
            end
        end else begin
            iter_d = iter_d;
        end
    end

    // Output decode of the upcoming state. It is registered so that outputs
    // are clean Moore signals.
    always_comb begin
        busy_d     = (state_d != IDLE);
        done_d     = 1'b0;
        bus_d      = 8'h00;
        bus_noe_d  = 1'b1;
        alu_ynwe_d = 1'b1;
        alu_noe_d  = 1'b1;
        case (state_d)
            ADD: begin
                bus_d      = add_operand(mcand_d, acc_lo_d[0]);
                bus_noe_d  = 1'b0;
                alu_ynwe_d = 1'b0;
            end
            READ: begin
                alu_noe_d = 1'b0;
            end
            DONE: begin
                done_d = 1'b1;
            end
            default: begin
                done_d = 1'b0;
            end
        endcase
    end

    // State, datapath and output registers with synchronous active-low reset.
    always_ff @(posedge i_clk) begin
        if (!i_nReset) begin
            state_q    <= IDLE;
            acc_hi_q   <= 8'h00;
            acc_lo_q   <= 8'h00;
            mcand_q    <= 8'h00;
            iter_q     <= 3'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            bus_q      <= 8'h00;
            bus_noe_q  <= 1'b1;
            alu_ynwe_q <= 1'b1;
            alu_noe_q  <= 1'b1;
        end else begin
            state_q    <= state_d;
            acc_hi_q   <= acc_hi_d;
            acc_lo_q   <= acc_lo_d;
            mcand_q    <= mcand_d;
            iter_q     <= iter_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            bus_q      <= bus_d;
            bus_noe_q  <= bus_noe_d;
            alu_ynwe_q <= alu_ynwe_d;
            alu_noe_q  <= alu_noe_d;
        end
    end

    assign o_busy        = busy_q;
    assign o_done        = done_q;
    assign o_product     = {acc_hi_q, acc_lo_q};
    assign o_aluA        = acc_hi_q;
    assign o_bus         = bus_q;
    assign o_busNOE      = bus_noe_q;
    assign o_ctrlAluYNWE = alu_ynwe_q;
    assign o_ctrlAluNOE  = alu_noe_q;
    assign o_ctrlAluSub  = 1'b0;
    assign o_ctrlAluOp   = ALU_OP_ADD;

endmodule

// File: tb/tb_alu_mul_seq.sv
// Self-checking bench for alu_mul_seq with a registered ALU model, a bus
// resolver and a product/latency scoreboard.
// Build option: ALU_MUL_SEQ_ZERO_SKIP_EN selects the expected latency.
module tb_alu_mul_seq;

    logic        clk;
    logic        nreset;
    logic        start;
    logic [7:0]  mcand;
    logic [7:0]  mplier;
    logic        busy;
    logic        done;
    logic [15:0] product;
    logic [7:0]  alu_a;
    logic [7:0]  seq_bus;
    logic        seq_noe;
    logic [7:0]  bus_s;
    logic        alu_ynwe;
    logic        alu_noe;
    logic        alu_sub;
    logic [1:0]  alu_op;
    logic [7:0]  alu_res_q = 8'h00;
    logic        alu_carry_q = 1'b0;

    typedef struct {
        logic [15:0] prod;
        int          due;
    } sb_t;

    sb_t sb_q[$];
    int  n_vec = 0;
    int  n_err = 0;
    int  cyc = 0;
    int  contention = 0;
    int  ctrl_bad = 0;
    int  ynwe_cnt = 0;
    logic done_prev = 1'b0;

    alu_mul_seq dut (
        .i_clk          (clk),
        .i_nReset       (nreset),
        .i_start        (start),
        .i_multiplicand (mcand),
        .i_multiplier   (mplier),
        .o_busy         (busy),
        .o_done         (done),
        .o_product      (product),
        .o_aluA         (alu_a),
        .o_bus          (seq_bus),
        .o_busNOE       (seq_noe),
        .i_bus          (bus_s),
        .i_flagCarry    (alu_carry_q),
        .o_ctrlAluYNWE  (alu_ynwe),
        .o_ctrlAluNOE   (alu_noe),
        .o_ctrlAluSub   (alu_sub),
        .o_ctrlAluOp    (alu_op)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // 8-bit ALU in ADD mode: the result and carry are registered on write enable.
    always @(posedge clk) begin
        if (alu_ynwe === 1'b0) begin
            {alu_carry_q, alu_res_q} <= {1'b0, alu_a} + {1'b0, bus_s};
        end
    end

    // Bus resolution: the bus pulls up when idle, and the ALU wins while it drives.
    always_comb begin
        bus_s = 8'hFF;
        if (seq_noe === 1'b0) bus_s = seq_bus;
        if (alu_noe === 1'b0) bus_s = alu_res_q;
    end

    function automatic int exp_lat(input logic [7:0] b);
`ifdef ALU_MUL_SEQ_ZERO_SKIP_EN
        return 8 + $countones(b);
`else
        return 16;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %0s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: sample away from the edge and run the bus and done monitors.
    task automatic tick();
        sb_t ent;
        @(negedge clk);
        #1;
        cyc++;
        if (seq_noe === 1'b0 && alu_noe === 1'b0) contention++;
        if (alu_sub !== 1'b0 || alu_op !== 2'b00) ctrl_bad++;
        if (alu_ynwe === 1'b0) ynwe_cnt++;
        if (done === 1'b1) begin
            chk("done_expected", {31'd0, sb_q.size() != 0}, 32'd1);
            chk("done_pulse", {31'd0, done_prev}, 32'd0);
            if (sb_q.size() != 0) begin
                ent = sb_q.pop_front();
                chk("product", {16'd0, product}, {16'd0, ent.prod});
                chk("latency", cyc, ent.due);
            end
        end
        done_prev = done;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_done"}, {31'd0, done}, 32'd0);
        chk({tag, "_product"}, {16'd0, product}, 32'd0);
        chk({tag, "_busNOE"}, {31'd0, seq_noe}, 32'd1);
        chk({tag, "_ynwe"}, {31'd0, alu_ynwe}, 32'd1);
        chk({tag, "_aluNOE"}, {31'd0, alu_noe}, 32'd1);
        chk({tag, "_sub"}, {31'd0, alu_sub}, 32'd0);
        chk({tag, "_op"}, {30'd0, alu_op}, 32'd0);
        chk({tag, "_bus"}, {24'd0, seq_bus}, 32'd0);
        chk({tag, "_aluA"}, {24'd0, alu_a}, 32'd0);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy !== 1'b0 && n < 40) begin
            tick();
            n++;
        end
        chk("idle_timeout", {31'd0, busy}, 32'd0);
    endtask

    task automatic start_mul(input logic [7:0] a, input logic [7:0] b);
        sb_t ent;
        wait_idle();
        mcand  = a;
        mplier = b;
        start  = 1'b1;
        ent.prod = {8'h00, a} * {8'h00, b};
        ent.due  = cyc + 1 + exp_lat(b);
        sb_q.push_back(ent);
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (sb_q.size() != 0 && n < 40) begin
            tick();
            n++;
        end
        chk("done_timeout", sb_q.size(), 32'd0);
        sb_q.delete();
    endtask

    task automatic run_mul(input logic [7:0] a, input logic [7:0] b);
        start_mul(a, b);
        wait_done();
    endtask

    initial begin
        int n;
        int base;
        nreset = 1'b0;
        start  = 1'b0;
        mcand  = 8'h00;
        mplier = 8'h00;
        tick();
        tick();
        check_reset("rst0");
        nreset = 1'b1;
        tick();

        run_mul(8'h0F, 8'h11);
        run_mul(8'hFF, 8'hFF);

        base = ynwe_cnt;
        run_mul(8'h80, 8'h00);
`ifdef ALU_MUL_SEQ_ZERO_SKIP_EN
        chk("ynwe_zero_b", ynwe_cnt - base, 32'd0);
`else
        chk("ynwe_zero_b", ynwe_cnt - base, 32'd8);
`endif

        // Start requests during ADD, READ and DONE must be ignored.
        start_mul(8'h12, 8'h34);
        n = 0;
        while (seq_noe !== 1'b0 && n < 20) begin
            tick();
            n++;
        end
        mcand  = 8'hFF;
        mplier = 8'hFF;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        if (alu_noe === 1'b0) begin
            start = 1'b1;
            tick();
            start = 1'b0;
        end
        n = 0;
        while (sb_q.size() != 0 && n < 40) begin
            tick();
            n++;
        end
        chk("ign_done_seen", sb_q.size(), 32'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (20) tick();
        chk("ign_busy", {31'd0, busy}, 32'd0);
        chk("ign_hold", {16'd0, product}, 32'h0000_03A8);

        // Reset in the middle of an operation aborts it.
        start_mul(8'hAA, 8'h55);
        repeat (6) tick();
        nreset = 1'b0;
        sb_q.delete();
        tick();
        check_reset("rst_mid_a");
        tick();
        check_reset("rst_mid_b");
        nreset = 1'b1;
        tick();
        run_mul(8'h03, 8'h07);

        for (int i = 0; i < 1000; i++) begin
            run_mul(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
        end

        chk("bus_contention", contention, 32'd0);
        chk("alu_ctrl_const", ctrl_bad, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
